// File: rtl/edge_gate_counter.sv
// Syncs and glitch-filters data_in, strobes filtered falling edges (SYNC_STAGES+FILT_LEN+1 cycles), and counts them per gate window.
// Window totals are held in count_out with count_valid until count_ready; no new window starts while a result is unconsumed.
module edge_gate_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int GATE_CYCLES = 1000000,
    parameter int CNT_W       = 16
) (
    input  logic             pll_inst1_CLKOUT0,
    input  logic             BTN0,
    input  logic             data_in,
    input  logic             gate_en,
    input  logic             count_ready,
    output logic             edge_pulse,
    output logic             data_filt,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
    localparam int TMR_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    logic [RUN_W-1:0]       run_q, run_d;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q;
    logic                   edge_q;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   win_ovf_q, win_ovf_d;
    logic [CNT_W-1:0]       count_out_q, count_out_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;

    logic [CNT_W-1:0]       cnt_inc;
    logic                   ovf_inc;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; idles high so reset never looks like a falling edge.
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge BTN0) begin
        if (!BTN0) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync_out != filt_q) begin
            if (run_q == RUN_LAST) begin
                filt_d = sync_out;
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pll_inst1_CLKOUT0 or negedge BTN0) begin
        if (!BTN0) begin
            run_q       <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            edge_q      <= 1'b0;
        end else begin
            run_q       <= run_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            edge_q      <= filt_prev_q & ~filt_q;
        end
    end

    // Saturating increment, shared by the in-window update and the final latch.
    always_comb begin
        cnt_inc = cnt_q;
        ovf_inc = win_ovf_q;
        if (edge_q) begin
            if (cnt_q == CNT_MAX) begin
                ovf_inc = 1'b1;
            end else begin
                cnt_inc = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        win_ovf_d   = win_ovf_q;
        count_out_d = count_out_q;
        ovf_d       = ovf_q;
        valid_d     = valid_q;
        case (state_q)
            S_IDLE: begin
                if (gate_en) begin
                    state_d   = S_GATE;
                    timer_d   = '0;
                    cnt_d     = '0;
                    win_ovf_d = 1'b0;
                end
            end
            S_GATE: begin
                if (!gate_en) begin
                    state_d = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    count_out_d = cnt_inc;
                    ovf_d       = ovf_inc;
                    valid_d     = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    timer_d   = timer_q + 1'b1;
                    cnt_d     = cnt_inc;
                    win_ovf_d = ovf_inc;
                end
            end
            S_HOLD: begin
                if (valid_q && count_ready) begin
                    valid_d = 1'b0;
                    if (gate_en) begin
                        state_d   = S_GATE;
                        timer_d   = '0;
                        cnt_d     = '0;
                        win_ovf_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pll_inst1_CLKOUT0 or negedge BTN0) begin
        if (!BTN0) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            cnt_q       <= '0;
            win_ovf_q   <= 1'b0;
            count_out_q <= '0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            win_ovf_q   <= win_ovf_d;
            count_out_q <= count_out_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
        end
    end

    assign edge_pulse  = edge_q;
    assign data_filt   = filt_q;
    assign count_out   = count_out_q;
    assign count_valid = valid_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q == S_GATE);

endmodule
